// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: decode/execute control in, instruction memory port, IF/ID register out.
// master = fetch stage, slave = surrounding pipeline and instruction memory.
interface fetch_stage_if;
  localparam int unsigned XLEN = 32;

  logic            stall_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic [XLEN-1:0] imem_addr_o;
  logic [XLEN-1:0] imem_instr_i;
  logic            if_id_valid_o;
  logic [XLEN-1:0] if_id_pc_o;
  logic [XLEN-1:0] if_id_pc4_o;
  logic [XLEN-1:0] if_id_instr_o;
  logic            misalign_o;
  logic [XLEN-1:0] fetch_count_o;

  modport master (
    input  stall_i,
    input  redirect_i,
    input  redirect_pc_i,
    input  imem_instr_i,
    output imem_addr_o,
    output if_id_valid_o,
    output if_id_pc_o,
    output if_id_pc4_o,
    output if_id_instr_o,
    output misalign_o,
    output fetch_count_o
  );

  modport slave (
    output stall_i,
    output redirect_i,
    output redirect_pc_i,
    output imem_instr_i,
    input  imem_addr_o,
    input  if_id_valid_o,
    input  if_id_pc_o,
    input  if_id_pc4_o,
    input  if_id_instr_o,
    input  misalign_o,
    input  fetch_count_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational instruction memory
// and loads the IF/ID register, with stall hold, redirect bubbles and a saturating fetch count.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] COUNT_MAX = '1;
  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  typedef enum logic [1:0] {
    MODE_ADVANCE  = 2'd0,
    MODE_STALL    = 2'd1,
    MODE_REDIRECT = 2'd2
  } mode_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{valid: 1'b0, pc: '0, pc4: '0, instr: NOP_INSTR};

  mode_e           mode_c;
  logic [XLEN-1:0] pc_q,       pc_d;
  if_id_t          if_id_q,    if_id_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] count_q,    count_d;

  // Redirect wins over stall; stall wins over advance.
  always_comb begin
    mode_c = MODE_ADVANCE;
    if (bus.redirect_i) begin
      mode_c = MODE_REDIRECT;
    end else if (bus.stall_i) begin
      mode_c = MODE_STALL;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    if_id_d    = if_id_q;
    misalign_d = 1'b0;
    count_d    = count_q;
    unique case (mode_c)
      MODE_REDIRECT: begin
        // Wrong-path word on imem_instr_i is dropped; target is forced aligned and flagged.
        pc_d           = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
        if_id_d.valid  = 1'b0;
        if_id_d.instr  = NOP_INSTR;
        misalign_d     = |bus.redirect_pc_i[1:0];
      end
      MODE_STALL: begin
      end
      MODE_ADVANCE: begin
        if_id_d.valid = 1'b1;
        if_id_d.pc    = pc_q;
        if_id_d.pc4   = pc_q + PC_STEP;
        if_id_d.instr = bus.imem_instr_i;
        pc_d          = pc_q + PC_STEP;
        if (count_q != COUNT_MAX) begin
          count_d = count_q + XLEN'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC_ALIGNED;
      if_id_q    <= IF_ID_RESET;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      if_id_q    <= if_id_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign bus.imem_addr_o   = pc_q;
  assign bus.if_id_valid_o = if_id_q.valid;
  assign bus.if_id_pc_o    = if_id_q.pc;
  assign bus.if_id_pc4_o   = if_id_q.pc4;
  assign bus.if_id_instr_o = if_id_q.instr;
  assign bus.misalign_o    = misalign_q;
  assign bus.fetch_count_o = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect traffic
// checked against a transaction-level model of the fetch stage.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  assign bus.imem_instr_i = mem[bus.imem_addr_o[9:2]];

  int n_vec;
  int n_err;

  // Reference model state
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_cnt;
  logic        m_valid, m_mis;

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_instr = NOP;
    m_cnt = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
  endtask

  // Drive one cycle of inputs, take one edge, and advance the model.
  task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
    logic [31:0] word;
    word = mem[m_pc[9:2]];
    bus.stall_i = st;
    bus.redirect_i = rd;
    bus.redirect_pc_i = rpc;
    @(posedge clk);
    #1;
    m_mis = 1'b0;
    if (rd) begin
      m_pc = rpc & ~32'h3;
      m_valid = 1'b0;
      m_instr = NOP;
      m_mis = (rpc % 4) != 0;
    end else if (!st) begin
      m_ifpc = m_pc;
      m_ifpc4 = m_pc + 32'd4;
      m_instr = word;
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0;
    rst_n = 1'b0;
    model_reset();
    #12;
    n_vec++;
    if (bus.imem_addr_o !== 32'h0 || bus.if_id_valid_o !== 1'b0 || bus.if_id_pc_o !== 32'h0 ||
        bus.if_id_pc4_o !== 32'h0 || bus.if_id_instr_o !== NOP || bus.misalign_o !== 1'b0 ||
        bus.fetch_count_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset: addr=%h v=%b pc=%h pc4=%h instr=%h mis=%b cnt=%h", bus.imem_addr_o,
               bus.if_id_valid_o, bus.if_id_pc_o, bus.if_id_pc4_o, bus.if_id_instr_o,
               bus.misalign_o, bus.fetch_count_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0, 32'h0);
      n_vec++;
      if (bus.if_id_pc_o !== 32'(4 * k) || bus.if_id_instr_o !== 32'(32'h100 + k) ||
          bus.if_id_valid_o !== 1'b1 || bus.if_id_pc4_o !== 32'(4 * k + 4)) begin
        n_err++;
        $display("FAIL seq edge%0d: pc=%h instr=%h v=%b pc4=%h, want pc=%h instr=%h", k + 1,
                 bus.if_id_pc_o, bus.if_id_instr_o, bus.if_id_valid_o, bus.if_id_pc4_o,
                 4 * k, 32'h100 + k);
      end
    end
    n_vec++;
    if (bus.fetch_count_o !== 32'd4) begin
      n_err++;
      $display("FAIL seq_count: got %0d want 4", bus.fetch_count_o);
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 32'h0);
      n_vec++;
      if (bus.if_id_pc_o !== 32'h4 || bus.imem_addr_o !== 32'h8 || bus.fetch_count_o !== 32'd2 ||
          bus.if_id_instr_o !== 32'h101) begin
        n_err++;
        $display("FAIL stall%0d: if_id_pc=%h addr=%h cnt=%0d instr=%h, want 4/8/2/101", k,
                 bus.if_id_pc_o, bus.imem_addr_o, bus.fetch_count_o, bus.if_id_instr_o);
      end
    end
    tick(1'b0, 1'b0, 32'h0);
    n_vec++;
    if (bus.if_id_pc_o !== 32'h8 || bus.if_id_instr_o !== 32'h102) begin
      n_err++;
      $display("FAIL stall_release: if_id_pc=%h instr=%h want 8/102", bus.if_id_pc_o,
               bus.if_id_instr_o);
    end
  endtask

  task automatic test_redirect();
    tick(1'b1, 1'b1, 32'h40);
    n_vec++;
    if (bus.if_id_valid_o !== 1'b0 || bus.if_id_instr_o !== NOP || bus.imem_addr_o !== 32'h40 ||
        bus.misalign_o !== 1'b0 || bus.if_id_pc_o !== 32'h8 || bus.fetch_count_o !== 32'd3) begin
      n_err++;
      $display("FAIL redirect: v=%b instr=%h addr=%h mis=%b pc=%h cnt=%0d", bus.if_id_valid_o,
               bus.if_id_instr_o, bus.imem_addr_o, bus.misalign_o, bus.if_id_pc_o,
               bus.fetch_count_o);
    end
    tick(1'b0, 1'b0, 32'h0);
    n_vec++;
    if (bus.if_id_pc_o !== 32'h40 || bus.if_id_valid_o !== 1'b1 || bus.if_id_instr_o !== 32'h110) begin
      n_err++;
      $display("FAIL redirect_follow: pc=%h v=%b instr=%h want 40/1/110", bus.if_id_pc_o,
               bus.if_id_valid_o, bus.if_id_instr_o);
    end
  endtask

  task automatic test_misalign();
    tick(1'b0, 1'b1, 32'h47);
    n_vec++;
    if (bus.imem_addr_o !== 32'h44 || bus.misalign_o !== 1'b1) begin
      n_err++;
      $display("FAIL misalign: addr=%h mis=%b want 44/1", bus.imem_addr_o, bus.misalign_o);
    end
    tick(1'b0, 1'b0, 32'h0);
    n_vec++;
    if (bus.misalign_o !== 1'b0 || bus.if_id_pc_o !== 32'h44) begin
      n_err++;
      $display("FAIL misalign_pulse: mis=%b pc=%h want 0/44", bus.misalign_o, bus.if_id_pc_o);
    end
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(1'b0, 1'b0, 32'h0);
    n_vec++;
    if (bus.if_id_pc_o !== 32'hFFFF_FFFC || bus.if_id_pc4_o !== 32'h0 || bus.imem_addr_o !== 32'h0) begin
      n_err++;
      $display("FAIL wrap1: pc=%h pc4=%h addr=%h", bus.if_id_pc_o, bus.if_id_pc4_o, bus.imem_addr_o);
    end
    tick(1'b0, 1'b0, 32'h0);
    n_vec++;
    if (bus.if_id_pc_o !== 32'h0 || bus.if_id_pc4_o !== 32'h4) begin
      n_err++;
      $display("FAIL wrap2: pc=%h pc4=%h want 0/4", bus.if_id_pc_o, bus.if_id_pc4_o);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.imem_addr_o !== 32'h0 || bus.if_id_valid_o !== 1'b0 || bus.if_id_pc_o !== 32'h0 ||
        bus.if_id_pc4_o !== 32'h0 || bus.if_id_instr_o !== NOP || bus.misalign_o !== 1'b0 ||
        bus.fetch_count_o !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: addr=%h v=%b pc=%h pc4=%h instr=%h cnt=%h", bus.imem_addr_o,
               bus.if_id_valid_o, bus.if_id_pc_o, bus.if_id_pc4_o, bus.if_id_instr_o,
               bus.fetch_count_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick(1'b0, 1'b0, 32'h0);
    n_vec++;
    if (bus.if_id_pc_o !== 32'h0 || bus.if_id_valid_o !== 1'b1 || bus.fetch_count_o !== 32'd1) begin
      n_err++;
      $display("FAIL post_reset_fetch: pc=%h v=%b cnt=%0d", bus.if_id_pc_o, bus.if_id_valid_o,
               bus.fetch_count_o);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    m_cnt = 32'hFFFF_FFFE;
    tick(1'b0, 1'b0, 32'h0);
    n_vec++;
    if (bus.fetch_count_o !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL sat_reach: cnt=%h want ffffffff", bus.fetch_count_o);
    end
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b0, 32'h0);
      n_vec++;
      if (bus.fetch_count_o !== 32'hFFFF_FFFF) begin
        n_err++;
        $display("FAIL sat_hold%0d: cnt=%h want ffffffff", k, bus.fetch_count_o);
      end
    end
  endtask

  task automatic test_random();
    logic st, rd;
    logic [31:0] rpc;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      tick(st, rd, rpc);
      n_vec++;
      if (bus.imem_addr_o !== m_pc || bus.if_id_valid_o !== m_valid || bus.if_id_pc_o !== m_ifpc ||
          bus.if_id_pc4_o !== m_ifpc4 || bus.if_id_instr_o !== m_instr ||
          bus.misalign_o !== m_mis || bus.fetch_count_o !== m_cnt) begin
        n_err++;
        $display("FAIL random%0d: addr=%h/%h v=%b/%b pc=%h/%h pc4=%h/%h instr=%h/%h mis=%b/%b cnt=%h/%h",
                 k, bus.imem_addr_o, m_pc, bus.if_id_valid_o, m_valid, bus.if_id_pc_o, m_ifpc,
                 bus.if_id_pc4_o, m_ifpc4, bus.if_id_instr_o, m_instr, bus.misalign_o, m_mis,
                 bus.fetch_count_o, m_cnt);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misalign();
    test_wrap();
    test_async_reset();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
